// File: rtl/vga_fb_pkg.sv
// Shared framebuffer constants, register map, STATUS bit positions and fill FSM states.
// Used by the rectangle-fill engine, the framebuffer top and the MCU header generator.
package vga_fb_pkg;

    localparam int unsigned FB_W_DEF  = 320;
    localparam int unsigned FB_H_DEF  = 240;
    localparam int unsigned FB_AW_DEF = 17;

    localparam logic [2:0] REG_X0    = 3'd0;
    localparam logic [2:0] REG_Y0    = 3'd1;
    localparam logic [2:0] REG_W     = 3'd2;
    localparam logic [2:0] REG_H     = 3'd3;
    localparam logic [2:0] REG_COLOR = 3'd4;
    localparam logic [2:0] REG_CTRL  = 3'd5;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_ABORT   = 1;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_CLIPPED = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        ROW,
        DONE
    } fill_state_t;

    // y*320 without a multiplier: (y<<8) + (y<<6)
    function automatic logic [FB_AW_DEF-1:0] row_base_320(input logic [7:0] y);
        logic [FB_AW_DEF-1:0] yw;
        yw = {9'd0, y};
        return (yw << 8) + (yw << 6);
    endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Framebuffer word-write port: valid/ready beat carrying bank, word address, byte lanes and data.
interface vga_rect_fill_if;
    logic        fb_wr_valid;
    logic        fb_wr_ready;
    logic        fb_wr_bank;
    logic [13:0] fb_wr_addr;
    logic [3:0]  fb_wr_ble;
    logic [31:0] fb_wr_data;

    modport master (
        output fb_wr_valid, fb_wr_bank, fb_wr_addr, fb_wr_ble, fb_wr_data,
        input  fb_wr_ready
    );

    modport slave (
        input  fb_wr_valid, fb_wr_bank, fb_wr_addr, fb_wr_ble, fb_wr_data,
        output fb_wr_ready
    );
endinterface

// File: rtl/vga_fill_ble.sv
// Byte-lane enable generator for one fill beat: trims the first word of a row from the
// left (lanes >= start lane) and the last word from the right (lanes <= end lane).
module vga_fill_ble (
    input  logic [1:0] s_lane,
    input  logic [1:0] e_lane,
    input  logic       is_first,
    input  logic       is_last,
    output logic [3:0] ble
);
    logic [3:0] first_mask;
    logic [3:0] last_mask;

    always_comb begin
        first_mask = 4'b1111 << s_lane;
        last_mask  = 4'b1111 >> (2'd3 - e_lane);
        ble        = 4'b1111;
        if (is_first) ble = ble & first_mask;
        if (is_last)  ble = ble & last_mask;
    end
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a programmed rectangle and streams 32-bit RGB332 word writes.
// Optional build macro RECT_FILL_PATTERN_EN selects a COLOR[15:8]/COLOR[7:0] checkerboard.
module vga_rect_fill
    import vga_fb_pkg::*;
#(
    parameter int unsigned FB_W  = FB_W_DEF,
    parameter int unsigned FB_H  = FB_H_DEF,
    parameter int unsigned FB_AW = FB_AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_wr,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    vga_rect_fill_if.master fb,
    output logic            busy,
    output logic            done
);
    localparam int unsigned PW     = FB_AW - 2;
    localparam logic [8:0]  FB_W_L = 9'(FB_W);
    localparam logic [7:0]  FB_H_L = 8'(FB_H);

    fill_state_t state_q, state_d;

    logic [8:0]  x0_r, w_r;
    logic [7:0]  y0_r, h_r, collo_r;
    logic [8:0]  x0_q, w_q;
    logic [7:0]  y0_q, h_q, collo_q;
`ifdef RECT_FILL_PATTERN_EN
    logic [7:0]  colhi_r, colhi_q, line_y_q;
`endif
    logic [FB_AW-1:0] s_q, e_q, s_nxt, row_base, s_calc, e_calc;
    logic [PW-1:0]    ptr_q;
    logic [7:0]       line_cnt_q;
    logic             clipped_q, abort_pend_q;

    logic       ctrl_wr, start_req, abort_req, accept, is_first, is_last, degenerate;
    logic       valid;
    logic [8:0] w_room, w_clip;
    logic [7:0] h_room, h_clip;
    logic [3:0] ble;
    logic [31:0] data_w;
    logic       unused_wdata;

    assign unused_wdata = ^reg_wdata[31:16];

    assign ctrl_wr   = reg_wr && (reg_addr == REG_CTRL);
    assign abort_req = ctrl_wr && reg_wdata[CTRL_ABORT];
    assign start_req = ctrl_wr && reg_wdata[CTRL_START] && !reg_wdata[CTRL_ABORT];
    assign accept    = valid && fb.fb_wr_ready;
    assign is_first  = (ptr_q == s_q[FB_AW-1:2]);
    assign is_last   = (ptr_q == e_q[FB_AW-1:2]);

    // Clip arithmetic on the working copy; only meaningful when not degenerate
    always_comb begin
        degenerate = (x0_q >= FB_W_L) || (y0_q >= FB_H_L) || (w_q == '0) || (h_q == '0);
        w_room     = FB_W_L - x0_q;
        h_room     = FB_H_L - y0_q;
        w_clip     = (w_q > w_room) ? w_room : w_q;
        h_clip     = (h_q > h_room) ? h_room : h_q;
        row_base   = (FB_W == 320) ? FB_AW'(row_base_320(y0_q)) : FB_AW'(32'(y0_q) * FB_W);
        s_calc     = row_base + FB_AW'(x0_q);
        e_calc     = s_calc + FB_AW'(w_clip) - FB_AW'(1);
        s_nxt      = s_q + FB_AW'(FB_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            IDLE:  if (start_req) state_d = SETUP;
            SETUP: state_d = (abort_req || degenerate) ? DONE : RUN;
            RUN: begin
                valid = 1'b1;
                if (accept) begin
                    if (abort_req || abort_pend_q) state_d = DONE;
                    else if (is_last)              state_d = ROW;
                end
            end
            ROW:   state_d = (abort_req || line_cnt_q == 8'd1) ? DONE : RUN;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_r    <= '0;
            y0_r    <= '0;
            w_r     <= '0;
            h_r     <= '0;
            collo_r <= '0;
`ifdef RECT_FILL_PATTERN_EN
            colhi_r <= '0;
`endif
        end else if (reg_wr) begin
            case (reg_addr)
                REG_X0:    x0_r <= reg_wdata[8:0];
                REG_Y0:    y0_r <= reg_wdata[7:0];
                REG_W:     w_r  <= reg_wdata[8:0];
                REG_H:     h_r  <= reg_wdata[7:0];
                REG_COLOR: begin
                    collo_r <= reg_wdata[7:0];
`ifdef RECT_FILL_PATTERN_EN
                    colhi_r <= reg_wdata[15:8];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            collo_q      <= '0;
`ifdef RECT_FILL_PATTERN_EN
            colhi_q      <= '0;
            line_y_q     <= '0;
`endif
            s_q          <= '0;
            e_q          <= '0;
            ptr_q        <= '0;
            line_cnt_q   <= '0;
            clipped_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_req) begin
                    x0_q         <= x0_r;
                    y0_q         <= y0_r;
                    w_q          <= w_r;
                    h_q          <= h_r;
                    collo_q      <= collo_r;
`ifdef RECT_FILL_PATTERN_EN
                    colhi_q      <= colhi_r;
`endif
                    clipped_q    <= 1'b0;
                    abort_pend_q <= 1'b0;
                end
                SETUP: if (!degenerate) begin
                    s_q        <= s_calc;
                    e_q        <= e_calc;
                    ptr_q      <= s_calc[FB_AW-1:2];
                    line_cnt_q <= h_clip;
                    clipped_q  <= (w_clip != w_q) || (h_clip != h_q);
`ifdef RECT_FILL_PATTERN_EN
                    line_y_q   <= y0_q;
`endif
                end
                RUN: begin
                    // A stalled beat must finish before an abort takes effect
                    if (accept) begin
                        if (!is_last) ptr_q <= ptr_q + PW'(1);
                    end else if (abort_req) begin
                        abort_pend_q <= 1'b1;
                    end
                end
                ROW: begin
                    s_q        <= s_nxt;
                    e_q        <= e_q + FB_AW'(FB_W);
                    ptr_q      <= s_nxt[FB_AW-1:2];
                    line_cnt_q <= line_cnt_q - 8'd1;
`ifdef RECT_FILL_PATTERN_EN
                    line_y_q   <= line_y_q + 8'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    vga_fill_ble u_ble (
        .s_lane   (s_q[1:0]),
        .e_lane   (e_q[1:0]),
        .is_first (is_first),
        .is_last  (is_last),
        .ble      (ble)
    );

    always_comb begin
        data_w = '0;
        for (int unsigned k = 0; k < 4; k++) begin
`ifdef RECT_FILL_PATTERN_EN
            data_w[8*k +: 8] = (1'(k) ^ line_y_q[0]) ? colhi_q : collo_q;
`else
            data_w[8*k +: 8] = collo_q;
`endif
        end
    end

    assign fb.fb_wr_valid = valid;
    assign fb.fb_wr_bank  = ptr_q[PW-1];
    assign fb.fb_wr_addr  = ptr_q[13:0];
    assign fb.fb_wr_ble   = ble;
    assign fb.fb_wr_data  = data_w;

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_X0:    reg_rdata = {23'd0, x0_r};
            REG_Y0:    reg_rdata = {24'd0, y0_r};
            REG_W:     reg_rdata = {23'd0, w_r};
            REG_H:     reg_rdata = {24'd0, h_r};
`ifdef RECT_FILL_PATTERN_EN
            REG_COLOR: reg_rdata = {16'd0, colhi_r, collo_r};
`else
            REG_COLOR: reg_rdata = {24'd0, collo_r};
`endif
            REG_CTRL: begin
                reg_rdata[STAT_BUSY]    = busy;
                reg_rdata[STAT_CLIPPED] = clipped_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: hand-computed beat lists, clipping, stall/abort and reset cases.
module tb_vga_rect_fill;
    import vga_fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wr = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic        busy, done;

    vga_rect_fill_if fb();

    vga_rect_fill #(.FB_W(320), .FB_H(240), .FB_AW(17)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .fb        (fb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        bq[$];
    logic [13:0] aq[$];
    logic [3:0]  lq[$];
    logic [31:0] dq[$];
    int          first_v, done_cyc, done_cnt;

    function automatic logic [31:0] exp_word(input logic [15:0] c, input int y);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
`ifdef RECT_FILL_PATTERN_EN
            w[8*k +: 8] = (((k ^ y) & 1) != 0) ? c[15:8] : c[7:0];
`else
            w[8*k +: 8] = c[7:0];
`endif
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        step();
        reg_wr = 1'b0;
    endtask

    // Returns in the cycle right after START was taken (engine in SETUP).
    task automatic start_fill(input int x0, input int y0, input int w, input int h);
        wr_reg(REG_X0, 32'(x0));
        wr_reg(REG_Y0, 32'(y0));
        wr_reg(REG_W,  32'(w));
        wr_reg(REG_H,  32'(h));
        wr_reg(REG_CTRL, 32'h1);
    endtask

    task automatic run_fill(input int max_cyc);
        bq.delete(); aq.delete(); lq.delete(); dq.delete();
        first_v = -1; done_cyc = -1; done_cnt = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (fb.fb_wr_valid === 1'b1 && first_v < 0) first_v = c;
            if (fb.fb_wr_valid === 1'b1 && fb.fb_wr_ready === 1'b1) begin
                bq.push_back(fb.fb_wr_bank); aq.push_back(fb.fb_wr_addr);
                lq.push_back(fb.fb_wr_ble);  dq.push_back(fb.fb_wr_data);
            end
            if (done === 1'b1) begin
                done_cnt++; done_cyc = c;
                step();
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (fb.fb_wr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", fb.fb_wr_valid); end
        reg_addr = REG_CTRL; #1;
        vectors++; if (reg_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want 0", reg_rdata); end
        reg_addr = REG_W; #1;
        vectors++; if (reg_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_w: got %h want 0", reg_rdata); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        wr_reg(REG_COLOR, 32'h00E0);
        start_fill(0, 0, 4, 1);
        run_fill(40);
        vectors++; if (first_v !== 2) begin miscompares++; $display("FAIL basic_latency: got %0d want 2", first_v); end
        vectors++; if (aq.size() !== 1) begin miscompares++; $display("FAIL basic_beats: got %0d want 1", aq.size()); end
        if (aq.size() >= 1) begin
            vectors++; if (bq[0] !== 1'b0) begin miscompares++; $display("FAIL basic_bank: got %b want 0", bq[0]); end
            vectors++; if (aq[0] !== 14'd0) begin miscompares++; $display("FAIL basic_addr: got %0d want 0", aq[0]); end
            vectors++; if (lq[0] !== 4'b1111) begin miscompares++; $display("FAIL basic_ble: got %b want 1111", lq[0]); end
            vectors++; if (dq[0] !== 32'hE0E0E0E0) begin miscompares++; $display("FAIL basic_data: got %h want E0E0E0E0", dq[0]); end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_after: done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_readback();
        logic [31:0] want;
        wr_reg(REG_COLOR, 32'h12E0);
        wr_reg(REG_X0, 32'hFFFF_FF37);
`ifdef RECT_FILL_PATTERN_EN
        want = 32'h12E0;
`else
        want = 32'h00E0;
`endif
        reg_addr = REG_COLOR; #1;
        vectors++; if (reg_rdata !== want) begin miscompares++; $display("FAIL rb_color: got %h want %h", reg_rdata, want); end
        reg_addr = REG_X0; #1;
        vectors++; if (reg_rdata !== 32'h137) begin miscompares++; $display("FAIL rb_x0: got %h want 137", reg_rdata); end
    endtask

    task automatic test_partial();
        start_fill(1, 0, 6, 1);
        run_fill(40);
        vectors++; if (aq.size() !== 2) begin miscompares++; $display("FAIL part_beats: got %0d want 2", aq.size()); end
        if (aq.size() >= 2) begin
            vectors++; if (aq[0] !== 14'd0 || lq[0] !== 4'b1110) begin miscompares++; $display("FAIL part_b0: got addr %0d ble %b want 0 1110", aq[0], lq[0]); end
            vectors++; if (aq[1] !== 14'd1 || lq[1] !== 4'b0111) begin miscompares++; $display("FAIL part_b1: got addr %0d ble %b want 1 0111", aq[1], lq[1]); end
            vectors++; if (dq[0] !== exp_word(16'h12E0, 0)) begin miscompares++; $display("FAIL part_data: got %h want %h", dq[0], exp_word(16'h12E0, 0)); end
        end
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL part_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_bank_switch();
        start_fill(0, 205, 320, 1);
        run_fill(200);
        vectors++; if (aq.size() !== 80) begin miscompares++; $display("FAIL bank_beats: got %0d want 80", aq.size()); end
        for (int i = 0; i < aq.size() && i < 80; i++) begin
            vectors++;
            if (bq[i] !== 1'b1 || aq[i] !== 14'(16 + i) || lq[i] !== 4'b1111) begin
                miscompares++;
                $display("FAIL bank_beat%0d: got bank %b addr %0d ble %b want 1 %0d 1111", i, bq[i], aq[i], lq[i], 16 + i);
            end
        end
        start_fill(252, 204, 8, 1);
        run_fill(40);
        vectors++; if (aq.size() !== 2) begin miscompares++; $display("FAIL cross_beats: got %0d want 2", aq.size()); end
        if (aq.size() >= 2) begin
            vectors++; if (bq[0] !== 1'b0 || aq[0] !== 14'h3FFF) begin miscompares++; $display("FAIL cross_b0: got bank %b addr %h want 0 3fff", bq[0], aq[0]); end
            vectors++; if (bq[1] !== 1'b1 || aq[1] !== 14'h0) begin miscompares++; $display("FAIL cross_b1: got bank %b addr %h want 1 0", bq[1], aq[1]); end
        end
    endtask

    task automatic test_clip();
        start_fill(318, 0, 10, 2);
        run_fill(40);
        vectors++; if (aq.size() !== 2) begin miscompares++; $display("FAIL clip_beats: got %0d want 2", aq.size()); end
        if (aq.size() >= 2) begin
            vectors++; if (aq[0] !== 14'd79 || lq[0] !== 4'b1100) begin miscompares++; $display("FAIL clip_b0: got addr %0d ble %b want 79 1100", aq[0], lq[0]); end
            vectors++; if (aq[1] !== 14'd159 || lq[1] !== 4'b1100) begin miscompares++; $display("FAIL clip_b1: got addr %0d ble %b want 159 1100", aq[1], lq[1]); end
        end
        reg_addr = REG_CTRL; #1;
        vectors++; if (reg_rdata !== 32'h2) begin miscompares++; $display("FAIL clip_status: got %h want 2", reg_rdata); end
    endtask

    task automatic test_stall_abort();
        fb.fb_wr_ready = 1'b1;
        start_fill(0, 0, 40, 2);
        step(); step(); step();           // words 0,1 accepted; word 2 valid now
        step();                           // word 2 accepted; word 3 presented
        fb.fb_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (fb.fb_wr_valid !== 1'b1 || fb.fb_wr_addr !== 14'd3 || fb.fb_wr_bank !== 1'b0 ||
                fb.fb_wr_ble !== 4'b1111 || fb.fb_wr_data !== exp_word(16'h12E0, 0)) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got v=%b addr=%0d ble=%b data=%h want 1 3 1111 %h", i,
                         fb.fb_wr_valid, fb.fb_wr_addr, fb.fb_wr_ble, fb.fb_wr_data, exp_word(16'h12E0, 0));
            end
            if (i == 4) begin reg_wr = 1'b1; reg_addr = REG_CTRL; reg_wdata = 32'h2; end
            step();
        end
        reg_wr = 1'b0;
        fb.fb_wr_ready = 1'b1;
        #1;
        vectors++; if (fb.fb_wr_valid !== 1'b1 || fb.fb_wr_addr !== 14'd3) begin miscompares++; $display("FAIL abort_pending: got v=%b addr=%0d want 1 3", fb.fb_wr_valid, fb.fb_wr_addr); end
        step();
        vectors++; if (done !== 1'b1 || fb.fb_wr_valid !== 1'b0) begin miscompares++; $display("FAIL abort_done: got done=%b v=%b want 1 0", done, fb.fb_wr_valid); end
        step();
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_abort_with_start();
        start_fill(0, 0, 320, 1);
        step(); step();                   // words 0 then 1 presented
        reg_wr = 1'b1; reg_addr = REG_CTRL; reg_wdata = 32'h3;
        step();
        reg_wr = 1'b0;
        vectors++; if (done !== 1'b1 || fb.fb_wr_valid !== 1'b0) begin miscompares++; $display("FAIL abst_done: got done=%b v=%b want 1 0", done, fb.fb_wr_valid); end
        step(); step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abst_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_zero_width();
        start_fill(0, 0, 0, 1);
        vectors++; if (fb.fb_wr_valid !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL zw_c1: got v=%b done=%b want 0 0", fb.fb_wr_valid, done); end
        step();
        vectors++; if (fb.fb_wr_valid !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL zw_c2: got v=%b done=%b want 0 1", fb.fb_wr_valid, done); end
        step();
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL zw_c3: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_reset_mid_fill();
        int pulses;
        start_fill(0, 0, 320, 2);
        step(); step(); step();
        vectors++; if (fb.fb_wr_valid !== 1'b1) begin miscompares++; $display("FAIL rmf_pre: got v=%b want 1", fb.fb_wr_valid); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (fb.fb_wr_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmf_async: got v=%b busy=%b want 0 0", fb.fb_wr_valid, busy); end
        step();
        #2 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done !== 1'b0 || fb.fb_wr_valid !== 1'b0) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rmf_quiet: got %0d active cycles want 0", pulses); end
        reg_addr = REG_X0; #1;
        vectors++; if (reg_rdata !== 32'h0) begin miscompares++; $display("FAIL rmf_regs: got %h want 0", reg_rdata); end
    endtask

    initial begin
        fb.fb_wr_ready = 1'b1;
        test_reset();
        test_basic();
        test_readback();
        test_partial();
        test_bank_switch();
        test_clip();
        test_stall_abort();
        test_abort_with_start();
        test_zero_width();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
